// File: rtl/ns_gnrl_rsp_router.sv
// Response router: keeps the grant index of every accepted request in an
// in-order ID FIFO and steers each returning response back to its requester.
module ns_gnrl_rsp_router #(
  parameter int ARBT_NUM = 4,
  parameter int DW       = 32,
  parameter int DEPTH    = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [ARBT_NUM-1:0]        grt_vec,
  input  logic                       grt_push,
  output logic                       tag_rdy,
  input  logic                       rsp_vld_i,
  output logic                       rsp_rdy_o,
  input  logic [DW-1:0]              rsp_dat_i,
  output logic [ARBT_NUM-1:0]        rsp_vld_o,
  input  logic [ARBT_NUM-1:0]        rsp_rdy_i,
  output logic [DW-1:0]              rsp_dat_o,
  output logic [$clog2(DEPTH+1)-1:0] outstd_cnt,
  output logic                       err
);

  localparam int IW = $clog2(ARBT_NUM);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [IW-1:0] mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [IW-1:0] head;
  logic [IW-1:0] grt_idx;
  logic          grt_onehot;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  assign full    = (outstd_cnt == CW'(DEPTH));
  assign empty   = (outstd_cnt == '0);
  assign tag_rdy = ~full;
  assign head    = mem[rptr];

  assign grt_onehot = (grt_vec != '0) &&
                      ((grt_vec & (grt_vec - ARBT_NUM'(1))) == '0);

  always_comb begin
    grt_idx = '0;
    for (int i = 0; i < ARBT_NUM; i++) begin
      if (grt_vec[i]) grt_idx = IW'(i);
    end
  end

  // Handshake: a transfer on any port happens on a cycle where both valid and
  // ready are high; valid never waits on ready. Only the head port sees valid,
  // and the downstream ready mirrors the head port's ready.
  always_comb begin
    rsp_vld_o = '0;
    for (int i = 0; i < ARBT_NUM; i++) begin
      rsp_vld_o[i] = rsp_vld_i & ~empty & (head == IW'(i));
    end
  end

  assign rsp_rdy_o = ~empty & rsp_rdy_i[head];
  assign rsp_dat_o = rsp_dat_i;

  assign push = grt_push & tag_rdy & grt_onehot;
  assign pop  = rsp_vld_i & rsp_rdy_o;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= grt_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr       <= '0;
      rptr       <= '0;
      outstd_cnt <= '0;
      err        <= 1'b0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      if (push && !pop)      outstd_cnt <= outstd_cnt + CW'(1);
      else if (pop && !push) outstd_cnt <= outstd_cnt - CW'(1);
      // Sticky: malformed grant, grant while full, or response with no ID.
      if ((grt_push && (!grt_onehot || full)) || (rsp_vld_i && empty))
        err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ns_gnrl_rsp_router.sv
// Directed bench for ns_gnrl_rsp_router: vector table plus hand-written
// sequences for wrap, fill/overflow, error and mid-cycle reset.
module tb_ns_gnrl_rsp_router;
  localparam int AN = 4;
  localparam int DW = 32;
  localparam int DEPTH = 8;
  localparam int CW = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AN-1:0] grt_vec = '0;
  logic          grt_push = 1'b0;
  logic          tag_rdy;
  logic          rsp_vld_i = 1'b0;
  logic          rsp_rdy_o;
  logic [DW-1:0] rsp_dat_i = '0;
  logic [AN-1:0] rsp_vld_o;
  logic [AN-1:0] rsp_rdy_i = '0;
  logic [DW-1:0] rsp_dat_o;
  logic [CW-1:0] outstd_cnt;
  logic          err;

  int n_checks = 0;
  int n_fail = 0;
  logic [AN-1:0] exp_q[$];

  ns_gnrl_rsp_router #(.ARBT_NUM(AN), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .grt_vec(grt_vec), .grt_push(grt_push),
    .tag_rdy(tag_rdy), .rsp_vld_i(rsp_vld_i), .rsp_rdy_o(rsp_rdy_o),
    .rsp_dat_i(rsp_dat_i), .rsp_vld_o(rsp_vld_o), .rsp_rdy_i(rsp_rdy_i),
    .rsp_dat_o(rsp_dat_o), .outstd_cnt(outstd_cnt), .err(err)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic          push;
    logic [AN-1:0] gvec;
    logic          rvld;
    logic [AN-1:0] rrdy;
    logic [DW-1:0] dat;
    logic [AN-1:0] e_vld;
    logic          e_rdy;
    logic          e_tag;
    logic [CW-1:0] e_cnt;
    logic          e_err;
  } vec_t;

  vec_t tbl[17];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver: applies one cycle of inputs at the falling edge
  task automatic drive(input logic push, input logic [AN-1:0] gvec, input logic rvld,
                       input logic [AN-1:0] rrdy, input logic [DW-1:0] dat);
    @(negedge clk);
    grt_push  = push;
    grt_vec   = gvec;
    rsp_vld_i = rvld;
    rsp_rdy_i = rrdy;
    rsp_dat_i = dat;
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    grt_push = 1'b0; grt_vec = '0; rsp_vld_i = 1'b0; rsp_rdy_i = '1;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // scoreboard: response at head must go to the oldest pushed grant
  task automatic expect_rsp(input string name);
    logic [DW-1:0] d;
    d = DW'($urandom_range(0, 32'hFFFF)) ^ 32'hA5A50000;
    drive(1'b0, '0, 1'b1, '1, d);
    if (exp_q.size() == 0) begin
      check({name, "_q_empty"}, 1, 0);
    end else begin
      check({name, "_vld"}, rsp_vld_o, exp_q[0]);
      check({name, "_rdy"}, rsp_rdy_o, 1);
      check({name, "_dat"}, rsp_dat_o, d);
      void'(exp_q.pop_front());
    end
  endtask

  task automatic push_grant(input logic [AN-1:0] g);
    drive(1'b1, g, 1'b0, '1, '0);
    exp_q.push_back(g);
  endtask

  initial begin
    tbl[0]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 32'h0,        4'b0000, 1'b0, 1'b1, 4'd0, 1'b0};
    tbl[1]  = '{1'b1, 4'b0010, 1'b0, 4'b1111, 32'h0,        4'b0000, 1'b0, 1'b1, 4'd0, 1'b0};
    tbl[2]  = '{1'b1, 4'b1000, 1'b0, 4'b1111, 32'h0,        4'b0000, 1'b1, 1'b1, 4'd1, 1'b0};
    tbl[3]  = '{1'b1, 4'b0001, 1'b0, 4'b1111, 32'h0,        4'b0000, 1'b1, 1'b1, 4'd2, 1'b0};
    tbl[4]  = '{1'b0, 4'b0000, 1'b1, 4'b1111, 32'hD0D0_0000, 4'b0010, 1'b1, 1'b1, 4'd3, 1'b0};
    tbl[5]  = '{1'b0, 4'b0000, 1'b1, 4'b1111, 32'hD1D1_1111, 4'b1000, 1'b1, 1'b1, 4'd2, 1'b0};
    tbl[6]  = '{1'b0, 4'b0000, 1'b1, 4'b1111, 32'hD2D2_2222, 4'b0001, 1'b1, 1'b1, 4'd1, 1'b0};
    tbl[7]  = '{1'b0, 4'b0000, 1'b0, 4'b1111, 32'h0,        4'b0000, 1'b0, 1'b1, 4'd0, 1'b0};
    tbl[8]  = '{1'b1, 4'b0100, 1'b0, 4'b1111, 32'h0,        4'b0000, 1'b0, 1'b1, 4'd0, 1'b0};
    tbl[9]  = '{1'b0, 4'b0000, 1'b1, 4'b1011, 32'hD3D3_3333, 4'b0100, 1'b0, 1'b1, 4'd1, 1'b0};
    tbl[10] = '{1'b0, 4'b0000, 1'b1, 4'b1011, 32'hD3D3_3333, 4'b0100, 1'b0, 1'b1, 4'd1, 1'b0};
    tbl[11] = '{1'b0, 4'b0000, 1'b1, 4'b1111, 32'hD3D3_3333, 4'b0100, 1'b1, 1'b1, 4'd1, 1'b0};
    tbl[12] = '{1'b0, 4'b0000, 1'b0, 4'b1111, 32'h0,        4'b0000, 1'b0, 1'b1, 4'd0, 1'b0};
    tbl[13] = '{1'b1, 4'b0001, 1'b0, 4'b1111, 32'h0,        4'b0000, 1'b0, 1'b1, 4'd0, 1'b0};
    tbl[14] = '{1'b1, 4'b0010, 1'b1, 4'b1111, 32'hD4D4_4444, 4'b0001, 1'b1, 1'b1, 4'd1, 1'b0};
    tbl[15] = '{1'b0, 4'b0000, 1'b1, 4'b1111, 32'hD5D5_5555, 4'b0010, 1'b1, 1'b1, 4'd1, 1'b0};
    tbl[16] = '{1'b0, 4'b0000, 1'b0, 4'b1111, 32'h0,        4'b0000, 1'b0, 1'b1, 4'd0, 1'b0};

    // reset asserted from time 0; check reset values before release
    #2;
    check("rst_tag_rdy", tag_rdy, 1);
    check("rst_vld_o", rsp_vld_o, 0);
    check("rst_rdy_o", rsp_rdy_o, 0);
    check("rst_cnt", outstd_cnt, 0);
    check("rst_err", err, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 17; v++) begin
      drive(tbl[v].push, tbl[v].gvec, tbl[v].rvld, tbl[v].rrdy, tbl[v].dat);
      check($sformatf("tbl%0d_vld_o", v), rsp_vld_o, tbl[v].e_vld);
      check($sformatf("tbl%0d_rdy_o", v), rsp_rdy_o, tbl[v].e_rdy);
      check($sformatf("tbl%0d_dat_o", v), rsp_dat_o, tbl[v].dat);
      check($sformatf("tbl%0d_tag_rdy", v), tag_rdy, tbl[v].e_tag);
      check($sformatf("tbl%0d_cnt", v), outstd_cnt, tbl[v].e_cnt);
      check($sformatf("tbl%0d_err", v), err, tbl[v].e_err);
    end

    // pointer wrap: 4 batches of 5 push/5 pop = 20 transactions
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 5; k++) begin
        logic [AN-1:0] g;
        g = AN'(1) << ((b * 5 + k * 3) % AN);
        push_grant(g);
      end
      drive(1'b0, '0, 1'b0, '1, '0);
      check("wrap_cnt5", outstd_cnt, 5);
      for (int k = 0; k < 5; k++) expect_rsp("wrap");
      drive(1'b0, '0, 1'b0, '1, '0);
      check("wrap_cnt0", outstd_cnt, 0);
      check("wrap_err", err, 0);
    end

    // fill to DEPTH, overflow push, pop with same-cycle push while full
    for (int k = 0; k < DEPTH; k++) push_grant(AN'(1) << ((k + 1) % AN));
    drive(1'b0, '0, 1'b0, '1, '0);
    check("full_tag_rdy", tag_rdy, 0);
    check("full_cnt", outstd_cnt, DEPTH);
    check("full_err", err, 0);
    drive(1'b1, 4'b0001, 1'b0, '1, '0);
    check("ovf_tag_rdy", tag_rdy, 0);
    drive(1'b0, '0, 1'b0, '1, '0);
    check("ovf_cnt", outstd_cnt, DEPTH);
    check("ovf_err", err, 1);
    drive(1'b1, 4'b0100, 1'b1, '1, 32'h1234_5678);
    check("fpop_vld", rsp_vld_o, exp_q[0]);
    check("fpop_rdy", rsp_rdy_o, 1);
    void'(exp_q.pop_front());
    push_grant(4'b0100);
    check("fpop_cnt7", outstd_cnt, DEPTH - 1);
    check("fpop_tag_rdy", tag_rdy, 1);
    drive(1'b0, '0, 1'b0, '1, '0);
    check("refill_cnt8", outstd_cnt, DEPTH);
    for (int k = 0; k < DEPTH; k++) expect_rsp("drain");
    drive(1'b0, '0, 1'b0, '1, '0);
    check("drain_cnt0", outstd_cnt, 0);

    // illegal multi-hot grant
    do_reset();
    drive(1'b1, 4'b0110, 1'b0, '1, '0);
    drive(1'b0, '0, 1'b0, '1, '0);
    check("ill_err", err, 1);
    check("ill_cnt", outstd_cnt, 0);
    // zero grant with push
    do_reset();
    drive(1'b1, 4'b0000, 1'b0, '1, '0);
    drive(1'b0, '0, 1'b0, '1, '0);
    check("zero_err", err, 1);
    check("zero_cnt", outstd_cnt, 0);

    // response while empty
    do_reset();
    drive(1'b0, '0, 1'b1, '1, 32'hEEEE_0001);
    check("emp_rdy_o", rsp_rdy_o, 0);
    check("emp_vld_o", rsp_vld_o, 0);
    check("emp_err_pre", err, 0);
    drive(1'b0, '0, 1'b0, '1, '0);
    check("emp_err", err, 1);
    check("emp_cnt", outstd_cnt, 0);

    // mid-cycle asynchronous reset with 3 outstanding
    do_reset();
    exp_q.delete();
    push_grant(4'b0001);
    push_grant(4'b0010);
    push_grant(4'b0100);
    drive(1'b0, '0, 1'b0, '1, '0);
    check("pre_rst_cnt", outstd_cnt, 3);
    check("pre_rst_rdy_o", rsp_rdy_o, 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_cnt", outstd_cnt, 0);
    check("arst_tag_rdy", tag_rdy, 1);
    check("arst_rdy_o", rsp_rdy_o, 0);
    check("arst_vld_o", rsp_vld_o, 0);
    check("arst_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    push_grant(4'b1000);
    expect_rsp("post_rst");
    drive(1'b0, '0, 1'b0, '1, '0);
    check("post_rst_cnt", outstd_cnt, 0);
    check("post_rst_err", err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ns_gnrl_rsp_router.md
Name: ns_gnrl_rsp_router

Overview:
Return-path companion to the round-robin request arbiter. Records the one-hot grant of every request accepted downstream in an in-order ID FIFO. Steers each returning downstream response back to the requester that issued it, with per-port valid/ready handshakes. Sits between the shared downstream slave response port and the ARBT_NUM requesters. Backpressures arbitration when the outstanding-ID FIFO is full.

Parameters:
ARBT_NUM, 4, number of requesters (must be >= 2).
DW, 32, response data width.
DEPTH, 8, maximum outstanding requests (power of two, >= 2).

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
grt_vec  input  ARBT_NUM  one-hot grant of the request accepted downstream this cycle
grt_push  input  1  request accepted downstream this cycle; qualifies grt_vec
tag_rdy  output  1  ID FIFO can accept a push; gates the arbiter's arbt_ena upstream
rsp_vld_i  input  1  downstream response valid
rsp_rdy_o  output  1  downstream response ready
rsp_dat_i  input  DW  downstream response data
rsp_vld_o  output  ARBT_NUM  per-requester response valid; at most one bit set
rsp_rdy_i  input  ARBT_NUM  per-requester response ready
rsp_dat_o  output  DW  response data, broadcast to all requesters
outstd_cnt  output  $clog2(DEPTH+1)  number of IDs held
err  output  1  sticky protocol error flag

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values:
  - Read and write pointers, outstd_cnt: 0.
  - err: 0.
  - tag_rdy: 1.
  - rsp_vld_o: 0.
  - rsp_rdy_o: 0.
- Storage:
  - FIFO of DEPTH entries, each $clog2(ARBT_NUM) bits holding the binary-encoded grant index.
  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - full = (outstd_cnt == DEPTH); empty = (outstd_cnt == 0).
- tag_rdy = ~full. It is combinational from the count only, with no dependence on a same-cycle pop.
- Push:
  - Occurs when grt_push & tag_rdy & grt_vec is one-hot.
  - The encoded index is written at wptr and wptr increments.
  - The new entry becomes visible at the head no earlier than the next cycle: one-cycle tag latency, no bypass.
- Illegal push:
  - Condition: grt_push with grt_vec zero or multi-hot.
  - No write. err is set on the next edge.
- Push while full: grt_push & ~tag_rdy is dropped and sets err.
- Response steering (combinational, zero latency), with head = FIFO[rptr]:
  - rsp_vld_o[i] = rsp_vld_i & ~empty & (head == i).
  - rsp_rdy_o = ~empty & rsp_rdy_i[head].
  - rsp_dat_o = rsp_dat_i, unconditionally.
- Pop:
  - Occurs on rsp_vld_i & rsp_rdy_o, i.e. a completed handshake at port head. rptr increments.
  - A requester not at the head never sees valid; its ready is ignored.
- Response while empty:
  - rsp_rdy_o stays 0, so the response stalls and is not consumed.
  - err is set on any cycle with rsp_vld_i & empty.
- Simultaneous push and pop (legal push, not full): both happen and outstd_cnt is unchanged.
- outstd_cnt update: +1 on push only, -1 on pop only. It never exceeds DEPTH and never underflows.
- err clears only on reset.
- Reset mid-operation:
  - All outstanding IDs are discarded and pointers return to 0.
  - Outputs take their reset values immediately (asynchronous).

Test Plan:
- Reset then idle → tag_rdy=1, rsp_vld_o=0, rsp_rdy_o=0, outstd_cnt=0, err=0.
- Push grants 4'b0010, 4'b1000, 4'b0001 on consecutive cycles; then return responses D0, D1, D2 with all rsp_rdy_i=1 → rsp_vld_o sequence 4'b0010, 4'b1000, 4'b0001; rsp_dat_o equals D0, D1, D2; outstd_cnt goes 3→0.
- Back-pressure: head is port 2 and rsp_rdy_i=4'b1011 → rsp_vld_o=4'b0100, rsp_rdy_o=0, no pop. Setting rsp_rdy_i[2]=1 → pop that cycle.
- Fill to DEPTH=8 pushes → tag_rdy=0. A 9th grt_push sets err and outstd_cnt stays 8. Same cycle: a pop with a second 4'b0100 push gives count 7, then 8; the pointers wrap correctly over 20 transactions.
- Push grt_vec=4'b0110 → no write, err=1 next cycle. rsp_vld_i=1 while empty → rsp_rdy_o=0, err=1.
- With 3 outstanding, assert rst_n=0 mid-cycle → outputs reset immediately. After release, outstd_cnt=0 and a new push/response round-trips correctly.
